// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit for the EX stage.
// It owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// The latency is set by a down-counter. The result is computed from the
// latched operands and written on the edge where the counter goes 1 -> 0.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU, which
// accumulate into {HI,LO} with MULT_CYCLES latency.
module mdu_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } op_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // Architectural and in-flight state
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;

  // Decode of the incoming op
  logic is_mul_in;
  logic is_div_in;
  logic is_acc_in;
  logic md_in;
  logic idle;
  logic issue;

  // Datapath results computed from the latched operands
  logic               mul_signed;
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] prod;
  logic               div_signed;
  logic               a_neg;
  logic               b_neg;
  logic               div_zero;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Classify the op on the input bus. Unknown codes behave as NONE.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // that no path through the case statement leaves a value held. A held
    // value would infer a latch.
    is_mul_in = 1'b0;
    is_div_in = 1'b0;
    is_acc_in = 1'b0;
    case (MDUOp)
      OP_MULT, OP_MULTU: is_mul_in = 1'b1;
      OP_DIV,  OP_DIVU:  is_div_in = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_acc_in = 1'b1;
`endif
      default: ;
    endcase
  end

  assign md_in = is_mul_in | is_div_in | is_acc_in;
  assign idle  = (cnt_q == '0);
  assign issue = start & ~flush & idle;

  // busy rises combinationally in the issue cycle, so the hazard unit can
  // stall the next MD instruction without a one-cycle gap.
  assign busy = (start & ~flush & md_in) | ~idle;

  assign HI = hi_q;
  assign LO = lo_q;

  // Full-width product: sign- or zero-extend both operands to 2*WIDTH. The
  // low 2*WIDTH bits of the product are then correct for both signednesses.
  always_comb begin
    mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    if (mul_signed) begin
      mul_a = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      mul_b = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end else begin
      mul_a = {{WIDTH{1'b0}}, a_q};
      mul_b = {{WIDTH{1'b0}}, b_q};
    end
    prod = mul_a * mul_b;
  end

  // Signed division is done on magnitudes, and the signs are applied after.
  // This truncates toward zero, and the remainder follows the dividend.
  // most-negative / -1 then wraps to most-negative with a zero remainder.
  always_comb begin
    div_signed = (op_q == OP_DIV);
    a_neg      = div_signed & a_q[WIDTH-1];
    b_neg      = div_signed & b_q[WIDTH-1];
    mag_a      = a_neg ? -a_q : a_q;
    mag_b      = b_neg ? -b_q : b_q;
    div_zero   = (b_q == '0);
    // A zero divisor is swapped for 1 only to keep the divider output
    // defined. The result is discarded in that case.
    divisor    = div_zero ? WIDTH'(1) : mag_b;
    q_mag      = mag_a / divisor;
    r_mag      = mag_a % divisor;
    quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem        = a_neg ? -r_mag : r_mag;
  end

  // Counter, operand latch and HI/LO update
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples pre-edge values, whatever order the statements are in.
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= OP_NONE;
      cnt_q <= '0;
    end else if (!idle) begin
      // An operation is in flight. A new start is ignored here.
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        case (op_q)
          OP_MULT, OP_MULTU: {hi_q, lo_q} <= prod;
          OP_DIV, OP_DIVU: begin
            if (!div_zero) begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end
`ifdef MDU_MADD_EN
          OP_MADD, OP_MADDU: {hi_q, lo_q} <= {hi_q, lo_q} + prod;
          OP_MSUB, OP_MSUBU: {hi_q, lo_q} <= {hi_q, lo_q} - prod;
`endif
          default: ;
        endcase
      end
    end else if (issue) begin
      if (md_in) begin
        a_q   <= A;
        b_q   <= B;
        op_q  <= op_e'(MDUOp);
        cnt_q <= is_div_in ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      end else if (MDUOp == OP_MTHI) begin
        hi_q <= A;
      end else if (MDUOp == OP_MTLO) begin
        lo_q <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors for mdu_unit with hand-computed HI/LO results.
// When MDU_MADD_EN is defined, the accumulate ops are exercised. Otherwise
// they are checked to behave as NONE.
module tb_mdu_unit;

  localparam logic [3:0] NONE  = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MTHI  = 4'd5;
  localparam logic [3:0] MTLO  = 4'd6;
  localparam logic [3:0] MADDU = 4'd8;
  localparam logic [3:0] MSUB  = 4'd9;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests  = 0;
  int failed = 0;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .flush (flush),
    .MDUOp (MDUOp),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Counts the negedges on which busy is still high after the issue edge.
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  // Issue one op, check busy in the issue cycle, then check the busy length.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic exp_busy, input int exp_cycles);
    int n;
    @(negedge clk);
    start = 1'b1; MDUOp = op; A = a; B = b;
    #1 check({tag, " busy_issue"}, 64'(busy), 64'(exp_busy));
    @(posedge clk);
    #1 start = 1'b0; MDUOp = NONE;
    count_busy(n);
    check({tag, " busy_cycles"}, 64'(n), 64'(exp_cycles));
  endtask

  task automatic check_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    check({tag, " HI"}, 64'(HI), 64'(hi));
    check({tag, " LO"}, 64'(LO), 64'(lo));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; flush = 1'b0; MDUOp = NONE; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check_hilo("reset", 32'h0, 32'h0);
    reset = 1'b0;

    run_op("mult -2*3", MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, 5);
    check_hilo("mult -2*3", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_op("multu max*max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5);
    check_hilo("multu max*max", 32'hFFFF_FFFE, 32'h0000_0001);

    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 10);
    check_hilo("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 1'b1, 10);
    check_hilo("div 7/-2", 32'h0000_0001, 32'hFFFF_FFFD);

    run_op("div minneg/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10);
    check_hilo("div minneg/-1", 32'h0, 32'h8000_0000);

    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 1'b1, 10);
    check_hilo("divu 100/7", 32'd2, 32'd14);

    run_op("mthi 0x11", MTHI, 32'h11, 32'h0, 1'b0, 0);
    run_op("mtlo 0x22", MTLO, 32'h22, 32'h0, 1'b0, 0);
    check_hilo("mthi/mtlo", 32'h11, 32'h22);

    run_op("divu 5/0", DIVU, 32'd5, 32'd0, 1'b1, 10);
    check_hilo("divu 5/0", 32'h11, 32'h22);

    run_op("mthi 0x1234", MTHI, 32'h1234, 32'h0, 1'b0, 0);
    check_hilo("mthi 0x1234", 32'h1234, 32'h22);

    // start together with flush: nothing issues
    @(negedge clk);
    start = 1'b1; flush = 1'b1; MDUOp = MULT; A = 32'd5; B = 32'd5;
    #1 check("flush busy_issue", 64'(busy), 64'd0);
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0; MDUOp = NONE;
    @(negedge clk);
    check("flush busy_after", 64'(busy), 64'd0);
    check_hilo("flush", 32'h1234, 32'h22);

    run_op("undefined op 11", 4'd11, 32'hABCD, 32'h1, 1'b0, 0);
    check_hilo("undefined op 11", 32'h1234, 32'h22);

`ifndef MDU_MADD_EN
    run_op("maddu disabled", MADDU, 32'd1, 32'd1, 1'b0, 0);
    check_hilo("maddu disabled", 32'h1234, 32'h22);
`endif

    // A second start during busy must be ignored
    @(negedge clk);
    start = 1'b1; MDUOp = MULT; A = 32'd6; B = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; MDUOp = NONE;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (n == 2) begin
        start = 1'b1; MDUOp = MULTU; A = 32'd100; B = 32'd100;
        @(posedge clk);
        #1 start = 1'b0; MDUOp = NONE;
      end
    end
    check("overlap busy_cycles", 64'(n), 64'd5);
    check_hilo("overlap", 32'h0, 32'd42);

    // Reset pulsed mid-divide, while the counter holds 4
    @(negedge clk);
    start = 1'b1; MDUOp = DIVU; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1 start = 1'b0; MDUOp = NONE;
    repeat (7) @(negedge clk);
    check("middiv busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("middiv busy_async", 64'(busy), 64'd0);
    check_hilo("middiv async", 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("middiv busy_later", 64'(busy), 64'd0);
    check_hilo("middiv later", 32'h0, 32'h0);

`ifdef MDU_MADD_EN
    run_op("mtlo ones", MTLO, 32'hFFFF_FFFF, 32'h0, 1'b0, 0);
    run_op("maddu 1*1", MADDU, 32'd1, 32'd1, 1'b1, 5);
    check_hilo("maddu 1*1", 32'h1, 32'h0);
    run_op("msub 1*1", MSUB, 32'd1, 32'd1, 1'b1, 5);
    check_hilo("msub 1*1", 32'h0, 32'hFFFF_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
